// File: rtl/memory_data_ctrl.sv
// Single-port data memory behind valid/ready request and response channels, with byte strobes,
// fixed LATENCY (1..15) and misaligned/out-of-range error reporting. Define MEMD_STATS_EN for request counters.
module memory_data_ctrl #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err
`ifdef MEMD_STATS_EN
    ,
    output logic [31:0]             stat_reads,
    output logic [31:0]             stat_writes,
    output logic [31:0]             stat_errs
`endif
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int IDX   = $clog2(DEPTH);
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [DATA_WIDTH-1:0]   pend_data_q;
    logic                    pend_err_q;
    logic                    resp_valid_q;
    logic [DATA_WIDTH-1:0]   resp_rdata_q;
    logic                    resp_err_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [IDX-1:0]          word_idx;
    logic                    misaligned;
    logic                    out_of_range;
    logic                    addr_err;
    logic                    accept;
    logic [BYTES-1:0]        byte_we;
    logic [DATA_WIDTH-1:0]   acc_data;

    assign word_idx   = req_addr[OFF+IDX-1:OFF];
    assign misaligned = |req_addr[OFF-1:0];

    // Addresses past the array never wrap; any bit above the index field is an error.
    generate
        if (ADDR_WIDTH > OFF + IDX) begin : g_range
            assign out_of_range = |req_addr[ADDR_WIDTH-1:OFF+IDX];
        end else begin : g_no_range
            assign out_of_range = 1'b0;
        end
    endgenerate

    assign addr_err  = misaligned || out_of_range;
    assign req_ready = reset_n && (state_q == S_IDLE);
    assign accept    = req_valid && req_ready;

    for (genvar gi = 0; gi < BYTES; gi++) begin : g_byte_we
        assign byte_we[gi] = accept && req_we && !addr_err && req_wstrb[gi];
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < BYTES; b++) begin
            if (byte_we[b]) begin
                mem[word_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
            end
        end
    end

    // Writes and errored requests respond with zero data.
    assign acc_data = (addr_err || req_we) ? '0 : mem[word_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            pend_data_q  <= '0;
            pend_err_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        pend_data_q <= acc_data;
                        pend_err_q  <= addr_err;
                        cnt_q       <= CNT_W'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= acc_data;
                            resp_err_q   <= addr_err;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= pend_data_q;
                        resp_err_q   <= pend_err_q;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state_q      <= S_IDLE;
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_rdata_q <= '0;
                    resp_err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

`ifdef MEMD_STATS_EN
    logic [31:0] stat_reads_q;
    logic [31:0] stat_writes_q;
    logic [31:0] stat_errs_q;

    // Errored requests count only as errors, never as reads or writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_reads_q  <= '0;
            stat_writes_q <= '0;
            stat_errs_q   <= '0;
        end else if (accept) begin
            if (addr_err) begin
                if (stat_errs_q != '1) stat_errs_q <= stat_errs_q + 32'd1;
            end else if (req_we) begin
                if (stat_writes_q != '1) stat_writes_q <= stat_writes_q + 32'd1;
            end else begin
                if (stat_reads_q != '1) stat_reads_q <= stat_reads_q + 32'd1;
            end
        end
    end

    assign stat_reads  = stat_reads_q;
    assign stat_writes = stat_writes_q;
    assign stat_errs   = stat_errs_q;
`endif

endmodule

// File: tb/tb_memory_data_ctrl.sv
// Bench for memory_data_ctrl: two instances (LATENCY 1 and 3) share one request stream and are
// checked against a byte-level memory model; stats ports are checked when MEMD_STATS_EN is defined.
module tb_memory_data_ctrl;

    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int DEPTH = 1024;
    localparam int BYTES = DW / 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [BYTES-1:0] req_wstrb;
    logic          resp_ready;

    logic          req_ready1, resp_valid1, resp_err1;
    logic [DW-1:0] resp_rdata1;
    logic          req_ready3, resp_valid3, resp_err3;
    logic [DW-1:0] resp_rdata3;
`ifdef MEMD_STATS_EN
    logic [31:0]   sr1, sw1, se1, sr3, sw3, se3;
`endif

    always #5 clk = ~clk;

    memory_data_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .LATENCY(1)) u_lat1 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready1), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid1), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata1), .resp_err(resp_err1)
`ifdef MEMD_STATS_EN
        , .stat_reads(sr1), .stat_writes(sw1), .stat_errs(se1)
`endif
    );

    memory_data_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .LATENCY(3)) u_lat3 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready3), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid3), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata3), .resp_err(resp_err3)
`ifdef MEMD_STATS_EN
        , .stat_reads(sr3), .stat_writes(sw3), .stat_errs(se3)
`endif
    );

    logic          dv_ready [2];
    logic          dv_valid [2];
    logic          dv_err   [2];
    logic [DW-1:0] dv_rdata [2];
    assign dv_ready[0] = req_ready1;  assign dv_ready[1] = req_ready3;
    assign dv_valid[0] = resp_valid1; assign dv_valid[1] = resp_valid3;
    assign dv_err[0]   = resp_err1;   assign dv_err[1]   = resp_err3;
    assign dv_rdata[0] = resp_rdata1; assign dv_rdata[1] = resp_rdata3;

    int dut_lat [2] = '{1, 3};

    // Reference model: memory contents plus a mask of bytes ever written (unwritten bytes are undefined).
    logic [DW-1:0] mdl_mem   [DEPTH];
    logic [DW-1:0] mdl_known [DEPTH];
    int unsigned   mdl_rd, mdl_wr, mdl_er;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic bit addr_is_err(input logic [AW-1:0] a);
        return ((a % BYTES) != 0) || (a >= AW'(DEPTH * BYTES));
    endfunction

    task automatic check_idle_outputs(input string tag, input logic exp_ready);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("%s ready u%0d", tag, d), 64'(dv_ready[d]), 64'(exp_ready));
            check_eq($sformatf("%s valid u%0d", tag, d), 64'(dv_valid[d]), 64'd0);
            check_eq($sformatf("%s rdata u%0d", tag, d), dv_rdata[d], 64'd0);
            check_eq($sformatf("%s err u%0d", tag, d), 64'(dv_err[d]), 64'd0);
        end
    endtask

    task automatic check_stats(input string tag);
`ifdef MEMD_STATS_EN
        check_eq({tag, " reads u0"},  64'(sr1), 64'(mdl_rd));
        check_eq({tag, " writes u0"}, 64'(sw1), 64'(mdl_wr));
        check_eq({tag, " errs u0"},   64'(se1), 64'(mdl_er));
        check_eq({tag, " reads u1"},  64'(sr3), 64'(mdl_rd));
        check_eq({tag, " writes u1"}, 64'(sw3), 64'(mdl_wr));
        check_eq({tag, " errs u1"},   64'(se3), 64'(mdl_er));
`else
        check_eq({tag, " model reads"}, 64'(dv_valid[0]), 64'd0);
`endif
    endtask

    // Apply the model's effect of accepting one request; returns expected response.
    task automatic model_accept(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                input logic [BYTES-1:0] wstrb, output bit err,
                                output logic [DW-1:0] exp_d, output logic [DW-1:0] mask);
        int idx;
        err   = addr_is_err(addr);
        exp_d = '0;
        mask  = '1;
        if (err) begin
            mdl_er++;
        end else begin
            idx = int'(addr / BYTES);
            if (we) begin
                mdl_wr++;
                for (int b = 0; b < BYTES; b++) begin
                    if (wstrb[b]) begin
                        mdl_mem[idx][b*8 +: 8]   = wdata[b*8 +: 8];
                        mdl_known[idx][b*8 +: 8] = 8'hFF;
                    end
                end
            end else begin
                mdl_rd++;
                exp_d = mdl_mem[idx];
                mask  = mdl_known[idx];
            end
        end
    endtask

    task automatic do_req(input string tag, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [BYTES-1:0] wstrb, input int hold);
        bit            err;
        logic [DW-1:0] exp_d, mask;
        int            seen [2];
        model_accept(we, addr, wdata, wstrb, err, exp_d, mask);
        $display("txn %s we=%0d addr=%h wstrb=%h err=%0d hold=%0d", tag, we, addr, wstrb, err, hold);
        @(negedge clk);
        check_eq({tag, " ready u0"}, 64'(dv_ready[0]), 64'd1);
        check_eq({tag, " ready u1"}, 64'(dv_ready[1]), 64'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_wstrb  = wstrb;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        req_wstrb = BYTES'($urandom);
        seen = '{0, 0};
        for (int cyc = 1; cyc <= 24 && (seen[0] == 0 || seen[1] == 0); cyc++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check_eq($sformatf("%s busy-ready u%0d", tag, d), 64'(dv_ready[d]), 64'd0);
                if (seen[d] == 0 && dv_valid[d]) begin
                    seen[d] = cyc;
                    check_eq($sformatf("%s latency u%0d", tag, d), 64'(cyc), 64'(dut_lat[d]));
                    check_eq($sformatf("%s rdata u%0d", tag, d), dv_rdata[d] & mask, exp_d & mask);
                    check_eq($sformatf("%s err u%0d", tag, d), 64'(dv_err[d]), 64'(err));
                end else if (seen[d] != 0) begin
                    check_eq($sformatf("%s held-valid u%0d", tag, d), 64'(dv_valid[d]), 64'd1);
                end
            end
        end
        for (int d = 0; d < 2; d++)
            if (seen[d] == 0) check_eq($sformatf("%s timeout u%0d", tag, d), 64'd0, 64'd1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check_eq($sformatf("%s hold-valid u%0d", tag, d), 64'(dv_valid[d]), 64'd1);
                check_eq($sformatf("%s hold-rdata u%0d", tag, d), dv_rdata[d] & mask, exp_d & mask);
                check_eq($sformatf("%s hold-err u%0d", tag, d), 64'(dv_err[d]), 64'(err));
                check_eq($sformatf("%s hold-ready u%0d", tag, d), 64'(dv_ready[d]), 64'd0);
            end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check_idle_outputs({tag, " post"}, 1'b1);
        resp_ready = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        bit            err;
        logic [DW-1:0] exp_d, mask;
        for (int i = 0; i < DEPTH; i++) begin
            mdl_mem[i]   = '0;
            mdl_known[i] = '0;
        end
        mdl_rd = 0; mdl_wr = 0; mdl_er = 0;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_wstrb  = '0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("in-reset", 1'b0);
        check_stats("in-reset stats");
        reset_n = 1'b1;
        #1;
        check_idle_outputs("after-reset", 1'b1);

        do_req("wr full", 1'b1, 64'h10, 64'h1122334455667788, 8'hFF, 0);
        do_req("rd full", 1'b0, 64'h10, 64'h0, 8'h00, 0);
        do_req("wr low", 1'b1, 64'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0);
        do_req("rd merged", 1'b0, 64'h10, 64'h0, 8'h00, 0);
        check_eq("model merged", mdl_mem[2], 64'h11223344AAAAAAAA);
        do_req("wr misaligned", 1'b1, 64'h13, 64'hDEADBEEFDEADBEEF, 8'hFF, 0);
        do_req("rd unchanged", 1'b0, 64'h10, 64'h0, 8'h00, 0);
        do_req("rd past end", 1'b0, 64'h2000, 64'h0, 8'h00, 0);
        do_req("rd last word", 1'b0, 64'h1FF8, 64'h0, 8'h00, 0);
        do_req("wr zero strb", 1'b1, 64'h10, 64'h5555555555555555, 8'h00, 0);
        do_req("rd after zero strb", 1'b0, 64'h10, 64'h0, 8'h00, 0);
        do_req("rd held", 1'b0, 64'h10, 64'h0, 8'h00, 5);

        // Reset while the LATENCY-3 instance is still waiting; the accepted write must remain.
        @(negedge clk);
        model_accept(1'b1, 64'h40, 64'h0102030405060708, 8'hFF, err, exp_d, mask);
        $display("txn reset-mid-wait we=1 addr=%h", 64'h40);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h40;
        req_wdata = 64'h0102030405060708; req_wstrb = 8'hFF; resp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("pre-reset valid u0", 64'(dv_valid[0]), 64'd1);
        check_eq("pre-reset valid u1", 64'(dv_valid[1]), 64'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check_idle_outputs("async-reset", 1'b0);
        mdl_rd = 0; mdl_wr = 0; mdl_er = 0;
        check_stats("async-reset stats");
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_idle_outputs("released", 1'b1);
        repeat (5) begin
            @(negedge clk);
            check_idle_outputs("no-response", 1'b1);
        end
        do_req("rd survived", 1'b0, 64'h40, 64'h0, 8'h00, 0);

        do_req("st wr a", 1'b1, 64'h80, 64'hCAFEF00D12345678, 8'hFF, 0);
        do_req("st rd a", 1'b0, 64'h80, 64'h0, 8'h00, 0);
        do_req("st rd b", 1'b0, 64'h10, 64'h0, 8'h00, 0);
        do_req("st misaligned", 1'b0, 64'h81, 64'h0, 8'h00, 0);
        check_stats("stats mix");

        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: a = 64'($urandom_range(0, 31)) * 8;
                3:       a = ($urandom_range(0, 1) != 0) ? 64'((DEPTH - 1) * BYTES) : 64'(DEPTH * BYTES);
                4:       a = 64'($urandom_range(0, 31)) * 8 + 64'($urandom_range(1, 7));
                default: a = {$urandom, $urandom};
            endcase
            do_req($sformatf("rnd%0d", t), 1'($urandom), a, {$urandom, $urandom},
                   8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
        end
        check_stats("stats final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
